// File: rtl/gray_stream_pkg.sv
// ---------------------------------------------------------------------------
// gray_stream_pkg
// Shared definitions for the gray_valid/gray pixel stream producer and the
// line-buffer filters that consume it.
//   stream_state_t : streamer FSM states
//   PIPE_LAT       : cycles from read request to pixel strobe
//   PIX_W          : grayscale pixel width
//   frame_mark_t   : sof/eol/eof markers travelling alongside each pixel
// ---------------------------------------------------------------------------
package gray_stream_pkg;

  localparam int PIPE_LAT = 2;
  localparam int PIX_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2,
    ST_FLUSH  = 2'd3
  } stream_state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } frame_mark_t;

endpackage

// File: rtl/gray_raster_counter.sv
// ---------------------------------------------------------------------------
// gray_raster_counter
// Raster position bookkeeping for gray_frame_streamer: column, row, linear
// read address and the horizontal-blanking cycle counter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_advance      : one pixel read is issued this cycle
//   i_blank_tick   : one blanking cycle elapses this cycle
//   o_col, o_row   : raster position of the read issued this cycle
//   o_addr         : linear read address (running counter, wraps at frame end)
//   o_last_col     : current column is the last of the row
//   o_last_row     : current row is the last of the frame
//   o_blank_done   : current blanking cycle is the last of the gap
// ---------------------------------------------------------------------------
module gray_raster_counter #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int HBLANK       = 4,
  parameter int ADDR_W       = 17,
  parameter int COL_W        = 9,
  parameter int ROW_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  input  logic              i_blank_tick,
  output logic [COL_W-1:0]  o_col,
  output logic [ROW_W-1:0]  o_row,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_col,
  output logic              o_last_row,
  output logic              o_blank_done
);

  // HBLANK may be 0; keep the counter at least one bit wide so it elaborates.
  localparam int BLANK_W    = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int BLANK_LAST = (HBLANK > 0) ? HBLANK - 1 : 0;

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [ADDR_W-1:0]  r_addr;
  logic [BLANK_W-1:0] r_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_blank <= '0;
    end else begin
      if (i_advance) begin
        if (o_last_col) begin
          r_col <= '0;
          if (o_last_row) begin
            r_row  <= '0;
            r_addr <= '0;
          end else begin
            r_row  <= r_row + ROW_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
          end
        end else begin
          r_col  <= r_col + COL_W'(1);
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
      if (i_blank_tick) begin
        r_blank <= o_blank_done ? '0 : r_blank + BLANK_W'(1);
      end
    end
  end

  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_addr       = r_addr;
  assign o_last_col   = (r_col == COL_W'(IMAGE_WIDTH - 1));
  assign o_last_row   = (r_row == ROW_W'(IMAGE_HEIGHT - 1));
  assign o_blank_done = (r_blank == BLANK_W'(BLANK_LAST));

endmodule

// File: rtl/gray_frame_streamer.sv
// ---------------------------------------------------------------------------
// gray_frame_streamer
// Reads an 8-bit grayscale frame from a synchronous-read frame memory and
// emits it as a row-major gray_valid/gray raster stream, with HBLANK idle
// cycles between rows and a start/busy/done handshake to the controller.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   i_start         : frame request pulse, honoured only when idle
//   o_busy          : high from start acceptance until done
//   o_done          : one-cycle pulse on the cycle after the last pixel
//   o_mem_rd_en     : frame memory read enable
//   o_mem_addr      : frame memory read address (row*IMAGE_WIDTH+col)
//   i_mem_rdata     : read data, valid one cycle after o_mem_rd_en
//   o_gray_valid    : pixel strobe
//   o_gray          : pixel value
//   o_sof/o_eol/o_eof : first pixel of frame / last of row / last of frame
// Build option: GRAY_STREAM_TESTPAT_EN replaces memory data with the test
// pattern (row+col) mod 256 and holds o_mem_rd_en low.
// ---------------------------------------------------------------------------
module gray_frame_streamer
  import gray_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int HBLANK       = 4,
  parameter int ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [PIX_W-1:0]  i_mem_rdata,
  output logic              o_gray_valid,
  output logic [PIX_W-1:0]  o_gray,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  stream_state_t r_state;
  stream_state_t w_state_next;
  logic          w_advance;
  logic          w_blank_tick;
  logic          w_accept;
  logic          w_frame_end;

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_blank_done;
  frame_mark_t      w_mark;

  // Stage 1 lines up with the memory read latency; stage 2 is the output.
  logic             r_p1_valid;
  frame_mark_t      r_p1_mark;
  logic             r_rd_en;
  logic             r_busy;
  logic             r_done;
  logic             r_gray_valid;
  logic [PIX_W-1:0] r_gray;
  frame_mark_t      r_out_mark;
`ifdef GRAY_STREAM_TESTPAT_EN
  logic [PIX_W-1:0] r_p1_pix;
`endif

  gray_raster_counter #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .HBLANK       (HBLANK),
    .ADDR_W       (ADDR_W),
    .COL_W        (COL_W),
    .ROW_W        (ROW_W)
  ) u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_advance    (w_advance),
    .i_blank_tick (w_blank_tick),
    .o_col        (w_col),
    .o_row        (w_row),
    .o_addr       (o_mem_addr),
    .o_last_col   (w_last_col),
    .o_last_row   (w_last_row),
    .o_blank_done (w_blank_done)
  );

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  // The last pixel leaves the output register this cycle; done follows it.
  assign w_frame_end = r_gray_valid && r_out_mark.eof;

  assign w_mark.sof = (w_col == '0) && (w_row == '0);
  assign w_mark.eol = w_last_col;
  assign w_mark.eof = w_last_col && w_last_row;

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_blank_tick = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        w_advance = 1'b1;
        if (w_last_col) begin
          if (w_last_row)       w_state_next = ST_FLUSH;
          else if (HBLANK != 0) w_state_next = ST_BLANK;
        end
      end
      ST_BLANK: begin
        w_blank_tick = 1'b1;
        if (w_blank_done) w_state_next = ST_ACTIVE;
      end
      ST_FLUSH: begin
        // Stay until the done pulse is out so a start arriving alongside
        // done is not taken; the next cycle is IDLE.
        if (r_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_p1_valid   <= 1'b0;
      r_p1_mark    <= '0;
      r_gray_valid <= 1'b0;
      r_gray       <= '0;
      r_out_mark   <= '0;
`ifdef GRAY_STREAM_TESTPAT_EN
      r_p1_pix     <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_p1_valid   <= (r_state == ST_ACTIVE);
      r_p1_mark    <= (r_state == ST_ACTIVE) ? w_mark : '0;
      r_gray_valid <= r_p1_valid;
      r_out_mark   <= r_p1_mark;
      r_done       <= w_frame_end;
      if (w_accept)         r_busy <= 1'b1;
      else if (w_frame_end) r_busy <= 1'b0;
`ifdef GRAY_STREAM_TESTPAT_EN
      r_rd_en  <= 1'b0;
      r_p1_pix <= PIX_W'(w_col) + PIX_W'(w_row);
      if (r_p1_valid) r_gray <= r_p1_pix;
`else
      // Read enable is registered alongside the state, so it is high
      // exactly in the cycles spent in ACTIVE.
      r_rd_en <= (w_state_next == ST_ACTIVE);
      if (r_p1_valid) r_gray <= i_mem_rdata;
`endif
    end
  end

  assign o_mem_rd_en  = r_rd_en;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_gray_valid = r_gray_valid;
  assign o_gray       = r_gray;
  assign o_sof        = r_out_mark.sof;
  assign o_eol        = r_out_mark.eol;
  assign o_eof        = r_out_mark.eof;

endmodule

// File: tb/tb_gray_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_gray_frame_streamer
// Two streamers (4x3 frame, HBLANK=2 and HBLANK=0) each driven by its own
// synchronous-read memory model. Frame records in a table are applied in a
// loop; every cycle of each frame is compared with a reference derived from
// the raster timing rules (pixel i is read at i + (i/W)*HBLANK cycles after
// acceptance and appears 2 cycles later; done follows the last pixel).
// ---------------------------------------------------------------------------
module tb_gray_frame_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct {
    int d;           // which DUT: 0 -> HBLANK=2, 1 -> HBLANK=0
    int hb;          // blanking of that DUT
    bit rnd;         // random memory contents instead of address pattern
    int extra_k;     // cycle of an extra start pulse while busy (-1 none)
    int abort_k;     // cycle at which reset is asserted (-1 none)
    int exp_cycles;  // expected cycles from acceptance to done
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start;

  wire        busy_w  [2];
  wire        done_w  [2];
  wire        rd_w    [2];
  wire [3:0]  addr_w  [2];
  wire        valid_w [2];
  wire [7:0]  gray_w  [2];
  wire        sof_w   [2];
  wire        eol_w   [2];
  wire        eof_w   [2];
  logic [7:0] rdata   [2];
  logic [7:0] mem     [2][16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(2)) u_dut_hb2 (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]),
    .o_busy(busy_w[0]), .o_done(done_w[0]),
    .o_mem_rd_en(rd_w[0]), .o_mem_addr(addr_w[0]), .i_mem_rdata(rdata[0]),
    .o_gray_valid(valid_w[0]), .o_gray(gray_w[0]),
    .o_sof(sof_w[0]), .o_eol(eol_w[0]), .o_eof(eof_w[0])
  );

  gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(0)) u_dut_hb0 (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]),
    .o_busy(busy_w[1]), .o_done(done_w[1]),
    .o_mem_rd_en(rd_w[1]), .o_mem_addr(addr_w[1]), .i_mem_rdata(rdata[1]),
    .o_gray_valid(valid_w[1]), .o_gray(gray_w[1]),
    .o_sof(sof_w[1]), .o_eol(eol_w[1]), .o_eof(eof_w[1])
  );

  // Synchronous-read frame memories, one cycle of latency.
  always @(posedge clk) begin
    if (rd_w[0]) rdata[0] <= mem[0][addr_w[0]];
    if (rd_w[1]) rdata[1] <= mem[1][addr_w[1]];
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, k, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec(input int d);
    return 32'({busy_w[d], done_w[d], rd_w[d], valid_w[d], sof_w[d], eol_w[d],
                eof_w[d], addr_w[d], gray_w[d]});
  endfunction

  function automatic logic [7:0] exp_pix(input int d, input int i);
`ifdef GRAY_STREAM_TESTPAT_EN
    return 8'((i / W) + (i % W));
`else
    return mem[d][i];
`endif
  endfunction

  task automatic run_frame(input vec_t v);
    int done_k;
    int obs_done;
    done_k   = N + (H - 1) * v.hb + 2;
    obs_done = -1;
    for (int a = 0; a < 16; a++)
      mem[v.d][a] = v.rnd ? 8'($urandom_range(0, 255)) : 8'(a);

    @(negedge clk);
    start[v.d] = 1'b1;
    @(negedge clk);          // accepted at the edge just passed: cycle 0
    start[v.d] = 1'b0;

    for (int k = 0; k <= done_k + 3; k++) begin
      logic       ev, er, es, el, ee;
      logic [7:0] ep;
      int         ea;
      if (k > 0) @(negedge clk);
      ev = 1'b0; er = 1'b0; es = 1'b0; el = 1'b0; ee = 1'b0; ep = 8'h00; ea = 0;
      for (int i = 0; i < N; i++) begin
        int rc;
        rc = i + (i / W) * v.hb;
        if (rc == k) begin
          er = 1'b1;
          ea = i;
        end
        if (rc + 2 == k) begin
          ev = 1'b1;
          ep = exp_pix(v.d, i);
          es = (i == 0);
          el = (i % W == W - 1);
          ee = (i == N - 1);
        end
      end
`ifdef GRAY_STREAM_TESTPAT_EN
      er = 1'b0;
`endif
      chk("gray_valid", k, 32'(valid_w[v.d]), 32'(ev));
      if (ev) chk("gray", k, 32'(gray_w[v.d]), 32'(ep));
      chk("sof_eol_eof", k, 32'({sof_w[v.d], eol_w[v.d], eof_w[v.d]}), 32'({es, el, ee}));
      chk("mem_rd_en", k, 32'(rd_w[v.d]), 32'(er));
      if (er) chk("mem_addr", k, 32'(addr_w[v.d]), 32'(ea));
      chk("busy", k, 32'(busy_w[v.d]), 32'(k < done_k));
      chk("done", k, 32'(done_w[v.d]), 32'(k == done_k));
      if (done_w[v.d] && obs_done < 0) obs_done = k;

      if (k == v.abort_k) begin
        rst_n = 1'b0;
        #1;
        chk("reset_outputs_zero", k, out_vec(v.d), 32'h0);
        chk("reset_outputs_zero_other", k, out_vec(1 - v.d), 32'h0);
        $display("frame dut=%0d hb=%0d aborted by reset at cycle %0d", v.d, v.hb, k);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start[v.d] = (k == v.extra_k);
    end
    chk("frame_cycles", 0, 32'(obs_done), 32'(v.exp_cycles));
    $display("frame dut=%0d hb=%0d rnd=%0d extra_start=%0d done_at=%0d",
             v.d, v.hb, v.rnd, v.extra_k, obs_done);
  endtask

  vec_t tbl [6];

  initial begin
    start = 2'b00;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) mem[d][a] = 8'h00;

    tbl[0] = '{0, 2, 1'b0, -1, -1, 18};  // basic frame, memory = address
    tbl[1] = '{1, 0, 1'b0, -1, -1, 14};  // no blanking, back-to-back rows
    tbl[2] = '{0, 2, 1'b1,  7, -1, 18};  // random data, start mid-row 1
    tbl[3] = '{0, 2, 1'b1, -1, 10, 18};  // reset while pixel 6 is out
    tbl[4] = '{0, 2, 1'b0, -1, -1, 18};  // fresh frame after the reset
    tbl[5] = '{1, 0, 1'b1,  4, -1, 14};  // random data, start while busy

    // Reset state, then idle after release.
    repeat (3) @(negedge clk);
    chk("reset_state_hb2", 0, out_vec(0), 32'h0);
    chk("reset_state_hb0", 0, out_vec(1), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release_hb2", 0, out_vec(0), 32'h0);
    chk("idle_after_release_hb0", 0, out_vec(1), 32'h0);

    for (int t = 0; t < 6; t++) begin
      run_frame(tbl[t]);
      // After a reset, nothing may come out until the next start.
      if (tbl[t].abort_k >= 0) begin
        repeat (2) @(negedge clk);
        chk("quiet_after_reset", 0, out_vec(tbl[t].d), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
